// File: rtl/uart_mem_dump_tx.sv
// uart_mem_dump_tx: sweeps an 8-bit address range of a 256x8 buffer memory
// and sends each location to a UART TX as a (data, address) byte pair,
// the same framing the byte-pair loader consumes.
module uart_mem_dump_tx #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] first_addr,
  input  logic [7:0] last_addr,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [7:0] mem_rdata,
  output logic [7:0] tx_byte,
  output logic       tx_send,
  input  logic       tx_busy,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    READ,
    LATCH,
    SEND_D,
    ACK_D,
    DRAIN_D,
    SEND_A,
    ACK_A,
    DRAIN_A,
    NEXT
  } state_t;

  state_t        state;
  logic [7:0]    cur;
  logic [7:0]    stop_addr;
  logic [7:0]    data;
  logic [CW-1:0] cnt;

  // Sweep sequencer: read, latch, then hand data and address bytes to the TX
  // with a busy handshake; a TX that never raises busy is released by timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      stop_addr <= '0;
      data      <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      tx_byte   <= '0;
      tx_send   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      tx_send <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          // The start coinciding with the done pulse is deliberately dropped.
          if (start && !done) begin
            cur       <= first_addr;
            stop_addr <= last_addr;
            mem_addr  <= first_addr;
            mem_rd_en <= 1'b1;
            busy      <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          mem_rd_en <= 1'b0;
          state     <= LATCH;
        end
        LATCH: begin
          data      <= mem_rdata;
          mem_rd_en <= 1'b0;
          state     <= SEND_D;
        end
        SEND_D: begin
          if (!tx_busy) begin
            tx_byte <= data;
            tx_send <= 1'b1;
            cnt     <= '0;
            state   <= ACK_D;
          end
        end
        ACK_D: begin
          if (tx_busy) begin
            state <= DRAIN_D;
          end else if (cnt == CNT_MAX) begin
            state <= SEND_A;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DRAIN_D: begin
          if (!tx_busy) state <= SEND_A;
        end
        SEND_A: begin
          if (!tx_busy) begin
            tx_byte <= cur;
            tx_send <= 1'b1;
            cnt     <= '0;
            state   <= ACK_A;
          end
        end
        ACK_A: begin
          if (tx_busy) begin
            state <= DRAIN_A;
          end else if (cnt == CNT_MAX) begin
            state <= NEXT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DRAIN_A: begin
          if (!tx_busy) state <= NEXT;
        end
        NEXT: begin
          if (cur == stop_addr) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cur       <= cur + 8'd1;
            mem_addr  <= cur + 8'd1;
            mem_rd_en <= 1'b1;
            state     <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_dump_tx.sv
// Bench for uart_mem_dump_tx: memory and UART TX models, a pair-sequence
// reference built from the sweep range, and directed plus random sweeps.
module tb_uart_mem_dump_tx;

  localparam int unsigned TB_ACK = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] first_addr;
  logic [7:0] last_addr;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata = '0;
  logic [7:0] tx_byte;
  logic       tx_send;
  logic       tx_busy;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  int         busy_len = 10;
  int         busy_cnt = 0;
  logic       force_busy = 1'b0;
  int         cyc = 0;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] got[$];
  int         got_t[$];
  logic [7:0] exp_q[$];
  int         done_count = 0;
  int         done_busy_bad = 0;
  int         send_busy_bad = 0;

  uart_mem_dump_tx #(.ACK_TIMEOUT(TB_ACK)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .tx_byte    (tx_byte),
    .tx_send    (tx_send),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  assign tx_busy = force_busy | (busy_cnt != 0);

  // Synchronous-read memory and a UART TX that stays busy busy_len cycles per send.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (tx_send && busy_len > 0) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // Monitor: record every sent byte with its cycle, and handshake violations.
  always @(negedge clk) begin
    if (tx_send) begin
      got.push_back(tx_byte);
      got_t.push_back(cyc);
      if (tx_busy) send_busy_bad++;
    end
    if (done) begin
      done_count++;
      if (busy) done_busy_bad++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: every address from first to last (8-bit wrap) yields (mem[a], a).
  task automatic build_exp(input logic [7:0] f, input logic [7:0] l);
    int n;
    logic [7:0] a;
    exp_q.delete();
    n = int'(8'(l - f)) + 1;
    for (int i = 0; i < n; i++) begin
      a = 8'(int'(f) + i);
      exp_q.push_back(mem[a]);
      exp_q.push_back(a);
    end
  endtask

  task automatic start_sweep(input logic [7:0] f, input logic [7:0] l);
    got.delete();
    got_t.delete();
    done_count    = 0;
    done_busy_bad = 0;
    send_busy_bad = 0;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", done, 1);
  endtask

  task automatic compare_pairs(input string tag);
    int n;
    @(negedge clk);
    check({tag, "_num_sends"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    check({tag, "_done_count"}, done_count, 1);
    check({tag, "_busy_low_at_done"}, done_busy_bad, 0);
    check({tag, "_send_while_busy"}, send_busy_bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_tx_byte"}, tx_byte, 0);
    check({tag, "_tx_send"}, tx_send, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [7:0] f;
    int         len;
    int         rel;
    int         t0;
    int         n;

    rst        = 1'b1;
    start      = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single location, slow TX; a start during the done cycle is ignored.
    busy_len = 10;
    mem[8'h10] = 8'hA5;
    build_exp(8'h10, 8'h10);
    start_sweep(8'h10, 8'h10);
    wait_done(400);
    first_addr = 8'h20;
    last_addr  = 8'h20;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    compare_pairs("single");
    repeat (20) @(negedge clk);
    check("done_cycle_start_ignored_busy", busy, 0);
    check("done_cycle_start_ignored_sends", got.size(), 2);

    // Wrapping range FE..01.
    busy_len = 3;
    mem[8'hFE] = 8'h11;
    mem[8'hFF] = 8'h22;
    mem[8'h00] = 8'h33;
    mem[8'h01] = 8'h44;
    build_exp(8'hFE, 8'h01);
    start_sweep(8'hFE, 8'h01);
    wait_done(800);
    compare_pairs("wrap");

    // TX held busy at start: first send lands the cycle after busy falls.
    busy_len   = 4;
    force_busy = 1'b1;
    build_exp(8'h30, 8'h30);
    start_sweep(8'h30, 8'h30);
    repeat (50) @(negedge clk);
    check("held_busy_no_send", got.size(), 0);
    rel = cyc;
    force_busy = 1'b0;
    wait_done(400);
    compare_pairs("held_busy");
    t0 = (got_t.size() > 0) ? got_t[0] : -1;
    check("held_busy_first_send_cycle", t0, rel + 1);

    // TX never busy: each byte released by the ack timeout.
    busy_len = 0;
    f = 8'($urandom);
    build_exp(f, 8'(f + 8'd2));
    start_sweep(f, 8'(f + 8'd2));
    wait_done(400);
    compare_pairs("timeout");
    if (got_t.size() >= 4) begin
      check("timeout_gap_pair0", got_t[1] - got_t[0], TB_ACK + 1);
      check("timeout_gap_pair1", got_t[3] - got_t[2], TB_ACK + 1);
    end else begin
      check("timeout_gap_sends_present", got_t.size(), 6);
    end

    // Reset while the address byte of the second pair is draining.
    busy_len = 10;
    start_sweep(8'h40, 8'h45);
    n = 0;
    while (got.size() < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_pair2", got.size(), 4);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_more_sends", got.size(), 4);
    check("abort_no_done", done_count, 0);
    busy_len = 2;
    f = 8'($urandom);
    build_exp(f, 8'(f + 8'd3));
    start_sweep(f, 8'(f + 8'd3));
    wait_done(800);
    compare_pairs("after_abort");

    // Start while busy with a different range is ignored.
    busy_len = 2;
    build_exp(8'h50, 8'h53);
    start_sweep(8'h50, 8'h53);
    repeat (5) @(negedge clk);
    first_addr = 8'h90;
    last_addr  = 8'h91;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(800);
    compare_pairs("restart_ignored");

    // Full 256-location dump.
    busy_len = 1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    f = 8'($urandom);
    build_exp(f, 8'(f - 8'd1));
    start_sweep(f, 8'(f - 8'd1));
    wait_done(20000);
    compare_pairs("full");

    // Random ranges, contents and TX latencies.
    for (int k = 0; k < 4; k++) begin
      busy_len = $urandom_range(0, 6);
      f   = 8'($urandom);
      len = $urandom_range(0, 4);
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      build_exp(f, 8'(int'(f) + len));
      start_sweep(f, 8'(int'(f) + len));
      wait_done(300 * (len + 1));
      compare_pairs($sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
